// File: rtl/seven_segment_scan_pkg.sv
// ---------------------------------------------------------------------------
// seven_segment_pkg
//
// Shared definitions for the digit-multiplexed seven-segment scanner:
//   - scan_state_t   : scanner FSM states (IDLE, BLANK, DRIVE)
//   - SEG_ALL_OFF_*  : segment-bus values that light nothing, per polarity
//   - dwell_cycles() : clock cycles spent on each digit slot
// ---------------------------------------------------------------------------
package seven_segment_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    localparam logic [7:0] SEG_ALL_OFF_HIGH = 8'h00;
    localparam logic [7:0] SEG_ALL_OFF_LOW  = 8'hFF;

    // Cycles per digit slot. Integer division: the slot rate is rounded
    // up slightly when CLOCK_HZ is not a multiple of DWELL_HZ.
    function automatic int dwell_cycles(input int clock_hz, input int dwell_hz);
        return clock_hz / dwell_hz;
    endfunction

endpackage : seven_segment_pkg

// File: rtl/seven_segment_scan_timer.sv
// ---------------------------------------------------------------------------
// scan_timer
//
// Slot timer for the seven-segment scanner. Counts 0 .. DWELL-1 and wraps
// on its own; a synchronous clear holds it at 0.
//
// Ports:
//   clk_i         system clock
//   rst_n_i       asynchronous active-low reset (timer -> 0)
//   clear_i       synchronous clear, forces the next value to 0
//   blank_done_o  timer == BLANK_CYCLES-1 (last blanked cycle of a slot)
//   slot_done_o   timer == DWELL-1        (last cycle of a slot)
// ---------------------------------------------------------------------------
module scan_timer
    import seven_segment_pkg::*;
#(
    parameter int DWELL        = 10,
    parameter int BLANK_CYCLES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    output logic blank_done_o,
    output logic slot_done_o
);

    localparam int TW = $clog2(DWELL);

    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
    localparam logic [TW-1:0] SLOT_LAST  = TW'(DWELL - 1);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    assign blank_done_o = (timer_q == BLANK_LAST);
    assign slot_done_o  = (timer_q == SLOT_LAST);

    // Wrap explicitly at DWELL-1 so a non-power-of-two DWELL never runs
    // past the slot length.
    always_comb begin
        timer_d = timer_q + 1'b1;
        if (clear_i || slot_done_o) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule : scan_timer

// File: rtl/seven_segment_scan.sv
// ---------------------------------------------------------------------------
// seven_segment_scan
//
// Digit-multiplexed driver for a common-segment seven-segment display.
// Each digit gets a slot of DWELL = CLOCK_HZ/DWELL_HZ cycles: BLANK_CYCLES
// with everything off (anti-ghosting), then the digit driven for the rest.
// A snapshot of all input patterns is taken at the start of every frame so
// a mid-scan change of the inputs never tears the displayed value.
//
// Ports:
//   clock             system clock
//   reset_n           asynchronous active-low reset
//   enable            scan enable; low blanks the display and parks in IDLE
//   seven_segment_in  [NUM-1:0][7:0] patterns, bit7 = DP, bits6:0 = g..a,
//                     logic-1 = lit, digit 0 rightmost
//   brightness        [3:0] PWM duty (only with SEVEN_SEGMENT_SCAN_DIMMING_EN)
//   segments          shared segment bus, polarity per ACTIVE_LOW
//   digit_sel         one-hot digit strobe, polarity per ACTIVE_LOW
//   frame_start       one-cycle pulse in the first cycle of the digit-0 slot
//
// Optional feature: define SEVEN_SEGMENT_SCAN_DIMMING_EN to add the
// brightness input and a free-running 4-bit PWM that gates the segments
// (digit_sel stays asserted) during DRIVE.
// ---------------------------------------------------------------------------
module seven_segment_scan
    import seven_segment_pkg::*;
#(
    parameter int NUM          = 6,
    parameter int CLOCK_HZ     = 50000000,
    parameter int DWELL_HZ     = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [NUM-1:0][7:0]   seven_segment_in,
`ifdef SEVEN_SEGMENT_SCAN_DIMMING_EN
    input  logic [3:0]            brightness,
`endif
    output logic [7:0]            segments,
    output logic [NUM-1:0]        digit_sel,
    output logic                  frame_start
);

    localparam int DWELL = dwell_cycles(CLOCK_HZ, DWELL_HZ);
    localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM - 1);

    localparam logic [7:0]     SEG_OFF = (ACTIVE_LOW != 0) ? SEG_ALL_OFF_LOW
                                                           : SEG_ALL_OFF_HIGH;
    localparam logic [NUM-1:0] SEL_OFF = (ACTIVE_LOW != 0) ? {NUM{1'b1}}
                                                           : {NUM{1'b0}};

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    scan_state_t              state_q,       state_d;
    logic [IDX_W-1:0]         index_q,       index_d;
    logic [NUM-1:0][7:0]      snapshot_q,    snapshot_d;
    logic [7:0]               segments_q,    segments_d;
    logic [NUM-1:0]           digit_sel_q,   digit_sel_d;
    logic                     frame_start_q, frame_start_d;

    logic                     timer_clear;
    logic                     blank_done;
    logic                     slot_done;
    logic                     seg_gate;
    logic [NUM-1:0]           onehot_d;

    scan_timer #(
        .DWELL        (DWELL),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_scan_timer (
        .clk_i        (clock),
        .rst_n_i      (reset_n),
        .clear_i      (timer_clear),
        .blank_done_o (blank_done),
        .slot_done_o  (slot_done)
    );

    // -----------------------------------------------------------------------
    // Optional PWM dimming of the segment bus
    // -----------------------------------------------------------------------
`ifdef SEVEN_SEGMENT_SCAN_DIMMING_EN
    logic [3:0] pwm_cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt_q <= 4'd0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 4'd1;
        end
    end

    // 15 is treated as fully on; otherwise lit for 'brightness' of every
    // 16 cycles, so 0 never lights.
    assign seg_gate = (brightness == 4'hF) || (pwm_cnt_q < brightness);
`else
    assign seg_gate = 1'b1;
`endif

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        index_d       = index_q;
        snapshot_d    = snapshot_q;
        frame_start_d = 1'b0;
        timer_clear   = 1'b0;

        // enable low dominates everything, including a frame wrap.
        if (!enable) begin
            state_d     = IDLE;
            index_d     = '0;
            timer_clear = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d       = BLANK;
                    index_d       = '0;
                    snapshot_d    = seven_segment_in;
                    frame_start_d = 1'b1;
                    timer_clear   = 1'b1;
                end
                BLANK: begin
                    if (blank_done) begin
                        state_d = DRIVE;
                    end
                end
                DRIVE: begin
                    if (slot_done) begin
                        state_d = BLANK;
                        if (index_q == IDX_LAST) begin
                            index_d       = '0;
                            snapshot_d    = seven_segment_in;
                            frame_start_d = 1'b1;
                        end else begin
                            index_d = index_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d     = IDLE;
                    index_d     = '0;
                    timer_clear = 1'b1;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output decode
    //
    // Decoded from the next state so the registered outputs line up with
    // the state register: the cycle that enters a slot is also the cycle
    // its outputs appear, and frame_start coincides with the first blank
    // cycle of digit 0.
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM; gi++) begin : g_onehot
        assign onehot_d[gi] = (index_d == IDX_W'(gi));
    end

    always_comb begin
        segments_d  = SEG_OFF;
        digit_sel_d = SEL_OFF;
        if (state_d == DRIVE) begin
            digit_sel_d = (ACTIVE_LOW != 0) ? ~onehot_d : onehot_d;
            if (seg_gate) begin
                segments_d = (ACTIVE_LOW != 0) ? ~snapshot_d[index_d]
                                               :  snapshot_d[index_d];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registers. Reset drives the outputs straight to OFF, so an asserted
    // reset_n blanks the display without waiting for a clock edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            index_q       <= '0;
            snapshot_q    <= '0;
            segments_q    <= SEG_OFF;
            digit_sel_q   <= SEL_OFF;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            snapshot_q    <= snapshot_d;
            segments_q    <= segments_d;
            digit_sel_q   <= digit_sel_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign segments    = segments_q;
    assign digit_sel   = digit_sel_q;
    assign frame_start = frame_start_q;

endmodule : seven_segment_scan

// File: tb/tb_seven_segment_scan.sv
// ---------------------------------------------------------------------------
// tb_seven_segment_scan
//
// NUM=4, DWELL=10, BLANK_CYCLES=2, ACTIVE_LOW=1. A frame-position model
// (cycles since frame start, slot = t/DWELL, lit when t%DWELL >= BLANK)
// is checked against the DUT after every clock edge; directed checks at
// the negative edge pin hand-computed values.
// ---------------------------------------------------------------------------
module tb_seven_segment_scan;

    localparam int NUM      = 4;
    localparam int CLOCK_HZ = 100;
    localparam int DWELL_HZ = 10;
    localparam int DWELL    = 10;
    localparam int BLANK    = 2;
    localparam int FRAME    = NUM * DWELL;

    logic                clock   = 1'b0;
    logic                reset_n = 1'b0;
    logic                enable  = 1'b0;
    logic [NUM-1:0][7:0] seg_in  = '0;
    logic [7:0]          segments;
    logic [NUM-1:0]      digit_sel;
    logic                frame_start;
`ifdef SEVEN_SEGMENT_SCAN_DIMMING_EN
    logic [3:0]          brightness = 4'hF;
`endif

    seven_segment_scan #(
        .NUM          (NUM),
        .CLOCK_HZ     (CLOCK_HZ),
        .DWELL_HZ     (DWELL_HZ),
        .BLANK_CYCLES (BLANK),
        .ACTIVE_LOW   (1)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .enable           (enable),
        .seven_segment_in (seg_in),
`ifdef SEVEN_SEGMENT_SCAN_DIMMING_EN
        .brightness       (brightness),
`endif
        .segments         (segments),
        .digit_sel        (digit_sel),
        .frame_start      (frame_start)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model: position within the frame
    // -----------------------------------------------------------------------
    bit         m_active = 1'b0;
    int         m_t      = 0;
    logic [7:0] m_snap [NUM];
    int         m_slot;
    int         m_off;
    bit         m_lit;
    logic [7:0] m_seg;
    logic [3:0] m_sel;
    int         m_frames = 0;

    always @(posedge clock) begin
        if (!reset_n || !enable) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_t      = 0;
            for (int i = 0; i < NUM; i++) m_snap[i] = seg_in[i];
        end else begin
            m_t = (m_t + 1) % FRAME;
            if (m_t == 0) begin
                for (int i = 0; i < NUM; i++) m_snap[i] = seg_in[i];
            end
        end
        #1;
        m_slot = m_t / DWELL;
        m_off  = m_t % DWELL;
        m_lit  = m_active && (m_off >= BLANK);
        m_seg  = m_lit ? ~m_snap[m_slot] : 8'hFF;
        m_sel  = m_lit ? ~(4'b0001 << m_slot) : 4'hF;
        check("model_segments",    32'(segments),    32'(m_seg));
        check("model_digit_sel",   32'(digit_sel),   32'(m_sel));
        check("model_frame_start", 32'(frame_start), 32'(m_active && m_t == 0));
        if (frame_start) begin
            m_frames++;
            $display("frame_start #%0d at %0t snapshot d0=%h d1=%h d2=%h d3=%h",
                     m_frames, $time, m_snap[0], m_snap[1], m_snap[2], m_snap[3]);
        end
    end

    // -----------------------------------------------------------------------
    // Directed stimulus and hand-computed expectations
    // -----------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        step(3);
        check("reset_segments",    32'(segments),    32'hFF);
        check("reset_digit_sel",   32'(digit_sel),   32'hF);
        check("reset_frame_start", 32'(frame_start), 32'h0);

        reset_n = 1'b1;
        step(3);
        check("idle_segments",    32'(segments),    32'hFF);
        check("idle_frame_start", 32'(frame_start), 32'h0);

        seg_in = {8'h3F, 8'h06, 8'h5B, 8'h4F};
        enable = 1'b1;
        step(1);                                   // t = 0
        check("t0_frame_start", 32'(frame_start), 32'h1);
        check("t0_segments",    32'(segments),    32'hFF);
        step(1);                                   // t = 1
        check("t1_frame_start", 32'(frame_start), 32'h0);
        check("t1_segments",    32'(segments),    32'hFF);
        step(1);                                   // t = 2
        check("t2_segments",  32'(segments),  32'hB0);
        check("t2_digit_sel", 32'(digit_sel), 32'hE);
        step(7);                                   // t = 9
        check("t9_segments",  32'(segments),  32'hB0);
        step(1);                                   // t = 10
        check("t10_segments",  32'(segments),  32'hFF);
        check("t10_digit_sel", 32'(digit_sel), 32'hF);
        step(2);                                   // t = 12
        check("t12_segments",  32'(segments),  32'hA4);
        check("t12_digit_sel", 32'(digit_sel), 32'hD);
        step(10);                                  // t = 22, digit 2
        check("t22_segments",  32'(segments),  32'hF9);
        check("t22_digit_sel", 32'(digit_sel), 32'hB);
        seg_in[0] = 8'h7F;
        step(18);                                  // t = 40
        check("t40_frame_start", 32'(frame_start), 32'h1);
        step(2);                                   // t = 42
        check("t42_segments",  32'(segments),  32'h80);
        check("t42_digit_sel", 32'(digit_sel), 32'hE);
        seg_in[1] = 8'h00;
        step(10);                                  // t = 52, old snapshot
        check("t52_segments", 32'(segments), 32'hA4);
        step(10);                                  // t = 62, digit 2 DRIVE
        enable = 1'b0;
        step(1);
        check("dis_segments",    32'(segments),    32'hFF);
        check("dis_digit_sel",   32'(digit_sel),   32'hF);
        check("dis_frame_start", 32'(frame_start), 32'h0);
        step(3);
        enable = 1'b1;
        step(1);
        check("reen_frame_start", 32'(frame_start), 32'h1);
        step(2);
        check("reen_segments",  32'(segments),  32'h80);
        check("reen_digit_sel", 32'(digit_sel), 32'hE);

        step(3);                                   // t = 5, mid DRIVE
        #2;
        reset_n = 1'b0;
        #1;
        check("async_segments",  32'(segments),  32'hFF);
        check("async_digit_sel", 32'(digit_sel), 32'hF);
        enable = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(3);
        check("post_rst_segments",    32'(segments),    32'hFF);
        check("post_rst_frame_start", 32'(frame_start), 32'h0);
        enable = 1'b1;
        step(1);                                   // t = 0
        check("rst_restart_frame_start", 32'(frame_start), 32'h1);
        step(39);                                  // t = 39, digit 3
        check("t39_segments",  32'(segments),  32'hC0);
        check("t39_digit_sel", 32'(digit_sel), 32'h7);
        enable = 1'b0;                             // drop on the wrap edge
        step(1);
        check("wrap_dis_frame_start", 32'(frame_start), 32'h0);
        check("wrap_dis_segments",    32'(segments),    32'hFF);
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_seven_segment_scan
